int_issue_queue: RTL and testbench
==================================

# int_issue_queue

Age-ordered issue queue for the integer functional unit. It sits between dispatch and the integer FU and is the consumer end of the common data bus: it snoops `CDB_output` every cycle, captures results whose tag matches a pending source operand, and wakes the waiting entries. It selects the oldest entry with both operands ready and issues it when the FU accepts. Its `issue_int` output is the strobe that drives the CDB reservation logic.

## Interface
Parameters:
- DEPTH, 4, number of queue entries (2..8)
- TAG_W, 6, ROB/physical tag width
- XLEN, 32, operand data width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; asynchronous, active-high; clears all entries
- flush  in  1  synchronous; invalidates all entries at the next edge
- dispatch_valid  in  1  dispatch presents an instruction
- dispatch_ready  out  1  queue can accept (count < DEPTH)
- dispatch_op  in  4  integer ALU opcode
- dispatch_rd_tag  in  TAG_W  destination tag
- dispatch_rs1_rdy, dispatch_rs2_rdy  in  1 each  operand already valid
- dispatch_rs1_tag, dispatch_rs2_tag  in  TAG_W each  producer tag when not ready
- dispatch_rs1_data, dispatch_rs2_data  in  XLEN each  operand value when ready
- CDB_output  in  cdb_bus  broadcast result; fields used: valid, tag, data
- int_fu_ready  in  1  integer FU can accept this cycle
- issue_int  out  1  instruction issued this cycle
- issue_op  out  4; issue_rd_tag  out  TAG_W; issue_rs1_data, issue_rs2_data  out  XLEN each
- iq_count  out  $clog2(DEPTH+1)  valid entries

## Operation
- Each entry holds: valid, op, rd_tag, and per source a rdy bit, tag and data. Slot 0 is the oldest entry.
- Wakeup: for every valid entry and source with rdy=0, if CDB_output.valid and the tag matches, then data is set to CDB data and rdy is set to 1 at the edge. Both sources of the same entry may wake in the same cycle.
- Dispatch capture: a dispatch whose source is not ready, but whose tag matches the CDB in the same cycle, is written with rdy=1 and the CDB data.
- Select: the lowest-index valid entry with both rdy=1 is the candidate.
- `issue_int` = candidate exists AND int_fu_ready AND !flush. Issue outputs are combinational from the candidate. When no candidate exists, they are 0.
- Removal: on issue, entries above the issued slot shift down by one. Their wakeup updates are applied during the shift.
- Insert: dispatch is accepted when dispatch_valid && dispatch_ready. The new entry is written to the slot at index (count − issued), which keeps the queue compacted.
- dispatch_ready depends only on the registered count. A full queue rejects dispatch even in a cycle where it issues.
- Priority within one edge: rst > flush > (issue, dispatch, wakeup). When flush is high, a dispatch in the same cycle is dropped.

## Timing
- Reset values: all entries invalid, iq_count=0, dispatch_ready=1, issue_int=0, all issue data/tag/op outputs 0.
- A dispatch with both operands ready is eligible one cycle after acceptance.
- A CDB wakeup in cycle N makes the entry eligible in cycle N+1 by default. See Configuration for the same-cycle case.
- There is no combinational path from dispatch inputs to issue outputs.
- Reset asserted mid-operation clears the queue immediately, without waiting for a clock edge. The first dispatch is accepted in the first cycle after deassertion.
- count equal to DEPTH: dispatch_ready=0. count equal to 0: issue_int=0 regardless of int_fu_ready.

## Configuration
- IQ_CDB_BYPASS_EN defined: an entry whose last missing operand matches the CDB in cycle N is eligible for select in cycle N. Its issue data is muxed from CDB data. This adds a CDB→issue combinational path.
- Undefined: select considers only registered rdy bits. Wakeup-to-issue latency is 1 cycle.

## Test plan
- Reset, then dispatch op=3, rd_tag=5, rs1=10, rs2=20, both ready, with int_fu_ready=1 → in the next cycle issue_int=1, issue_rd_tag=5, data 10/20, then iq_count returns to 0.
- Dispatch entry A waiting on tag 7, then ready entry B. Next cycle: B issues first. Then drive CDB tag=7, data=0x55 → A issues the following cycle with rs1=0x55, or in the same cycle if IQ_CDB_BYPASS_EN is defined.
- Fill DEPTH=4 entries waiting on tag 9 → dispatch_ready=0 and a 5th dispatch is not accepted. Broadcast tag 9 → entries issue in order 0,1,2,3, one per cycle.
- Hold int_fu_ready=0 with 2 ready entries for 3 cycles → issue_int stays 0 and iq_count=2. Release it → the oldest entry issues first.
- Dispatch with rs2 not ready and tag 12, in the same cycle as CDB tag 12, data 0xAB → the entry is eligible next cycle with rs2=0xAB.
- Assert flush with 3 entries present and a dispatch in the same cycle → next cycle iq_count=0 and issue_int=0. Repeat the setup with rst asserted mid-cycle → the queue clears immediately.

Source files
------------

// File: rtl/int_issue_queue.sv
// Age-ordered, compacting issue queue for the integer FU; snoops the CDB for operand wakeup.
// Optional macro IQ_CDB_BYPASS_EN: lets a CDB wakeup select and issue in the same cycle.
package int_issue_queue_pkg;
  parameter int CDB_TAG_W = 6;
  parameter int CDB_XLEN  = 32;
  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  data;
  } cdb_bus;
endpackage

module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [3:0]                 dispatch_op,
  input  logic [TAG_W-1:0]           dispatch_rd_tag,
  input  logic                       dispatch_rs1_rdy,
  input  logic                       dispatch_rs2_rdy,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag,
  input  logic [XLEN-1:0]            dispatch_rs1_data,
  input  logic [XLEN-1:0]            dispatch_rs2_data,
  input  cdb_bus                     CDB_output,
  input  logic                       int_fu_ready,
  output logic                       issue_int,
  output logic [3:0]                 issue_op,
  output logic [TAG_W-1:0]           issue_rd_tag,
  output logic [XLEN-1:0]            issue_rs1_data,
  output logic [XLEN-1:0]            issue_rs2_data,
  output logic [$clog2(DEPTH+1)-1:0] iq_count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [TAG_W-1:0] rd_tag;
    logic             rdy1;
    logic [TAG_W-1:0] tag1;
    logic [XLEN-1:0]  data1;
    logic             rdy2;
    logic [TAG_W-1:0] tag2;
    logic [XLEN-1:0]  data2;
  } entry_t;

  entry_t           q     [DEPTH];
  entry_t           woken [DEPTH];
  entry_t           nxt   [DEPTH];
  entry_t           disp_e;
  entry_t           cand;
  logic [DEPTH-1:0] elig;
  logic             found;
  logic [IW-1:0]    sel;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    ins_idx;
  logic             accept;
  logic             cdb_v;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  assign cdb_v    = CDB_output.valid;
  assign cdb_tag  = TAG_W'(CDB_output.tag);
  assign cdb_data = XLEN'(CDB_output.data);

  // Registered entries with this cycle's CDB result merged into waiting sources.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      if (q[i].valid && !q[i].rdy1 && cdb_v && q[i].tag1 == cdb_tag) begin
        woken[i].rdy1  = 1'b1;
        woken[i].data1 = cdb_data;
      end
      if (q[i].valid && !q[i].rdy2 && cdb_v && q[i].tag2 == cdb_tag) begin
        woken[i].rdy2  = 1'b1;
        woken[i].data2 = cdb_data;
      end
`ifdef IQ_CDB_BYPASS_EN
      elig[i] = woken[i].valid && woken[i].rdy1 && woken[i].rdy2;
`else
      elig[i] = q[i].valid && q[i].rdy1 && q[i].rdy2;
`endif
    end
  end

  // Oldest eligible entry wins: scan downward so the lowest index is written last.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

`ifdef IQ_CDB_BYPASS_EN
  assign cand = woken[sel];
`else
  assign cand = q[sel];
`endif

  assign issue_int      = found && int_fu_ready && !flush;
  assign issue_op       = found ? cand.op     : '0;
  assign issue_rd_tag   = found ? cand.rd_tag : '0;
  assign issue_rs1_data = found ? cand.data1  : '0;
  assign issue_rs2_data = found ? cand.data2  : '0;

  assign dispatch_ready = count < CW'(DEPTH);
  assign iq_count       = count;
  assign accept         = dispatch_valid && dispatch_ready && !flush;
  assign ins_idx        = count - CW'(issue_int);

  always_comb begin
    disp_e        = '0;
    disp_e.valid  = 1'b1;
    disp_e.op     = dispatch_op;
    disp_e.rd_tag = dispatch_rd_tag;
    disp_e.rdy1   = dispatch_rs1_rdy;
    disp_e.tag1   = dispatch_rs1_tag;
    disp_e.data1  = dispatch_rs1_data;
    disp_e.rdy2   = dispatch_rs2_rdy;
    disp_e.tag2   = dispatch_rs2_tag;
    disp_e.data2  = dispatch_rs2_data;
    if (!dispatch_rs1_rdy && cdb_v && dispatch_rs1_tag == cdb_tag) begin
      disp_e.rdy1  = 1'b1;
      disp_e.data1 = cdb_data;
    end
    if (!dispatch_rs2_rdy && cdb_v && dispatch_rs2_tag == cdb_tag) begin
      disp_e.rdy2  = 1'b1;
      disp_e.data2 = cdb_data;
    end
  end

  // Compaction: slots at or above the issued one take their upper neighbour.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = woken[i];
      if (issue_int && IW'(i) >= sel) begin
        if (i < DEPTH - 1) nxt[i] = woken[(i + 1) % DEPTH];
        else               nxt[i] = '0;
      end
      if (accept && ins_idx == CW'(i)) nxt[i] = disp_e;
      if (flush) nxt[i] = '0;
    end
    count_nxt = flush ? '0 : count - CW'(issue_int) + CW'(accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Randomized and directed bench for int_issue_queue against an age-ordered queue model.
// Honours IQ_CDB_BYPASS_EN so the model matches the build being simulated.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [3:0]       dispatch_op;
  logic [TAG_W-1:0] dispatch_rd_tag;
  logic             dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [TAG_W-1:0] dispatch_rs1_tag, dispatch_rs2_tag;
  logic [XLEN-1:0]  dispatch_rs1_data, dispatch_rs2_data;
  cdb_bus           CDB_output;
  logic             int_fu_ready;
  logic             issue_int;
  logic [3:0]       issue_op;
  logic [TAG_W-1:0] issue_rd_tag;
  logic [XLEN-1:0]  issue_rs1_data, issue_rs2_data;
  logic [$clog2(DEPTH+1)-1:0] iq_count;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs2_rdy(dispatch_rs2_rdy),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .CDB_output(CDB_output), .int_fu_ready(int_fu_ready),
    .issue_int(issue_int), .issue_op(issue_op), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .iq_count(iq_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: oldest-first list of pending instructions.
  typedef struct {
    logic [3:0]       op;
    logic [TAG_W-1:0] rd;
    logic             r1, r2;
    logic [TAG_W-1:0] t1, t2;
    logic [XLEN-1:0]  d1, d2;
  } m_entry_t;
  m_entry_t mq[$];
  int       exp_cand;
  logic     exp_issue;

  function automatic bit cdb_hit(input logic [TAG_W-1:0] t);
    return CDB_output.valid && CDB_output.tag == t;
  endfunction

  task automatic model_check();
    bit r1, r2;
    logic [XLEN-1:0] d1, d2;
    exp_cand = -1;
    for (int i = 0; i < mq.size(); i++) begin
      r1 = mq[i].r1;
      r2 = mq[i].r2;
`ifdef IQ_CDB_BYPASS_EN
      r1 = r1 || cdb_hit(mq[i].t1);
      r2 = r2 || cdb_hit(mq[i].t2);
`endif
      if (r1 && r2) begin
        exp_cand = i;
        break;
      end
    end
    exp_issue = (exp_cand >= 0) && int_fu_ready && !flush;
    check_eq("issue_int", 64'(issue_int), 64'(exp_issue));
    check_eq("dispatch_ready", 64'(dispatch_ready), 64'(mq.size() < DEPTH));
    check_eq("iq_count", 64'(iq_count), 64'(mq.size()));
    if (exp_cand >= 0) begin
      d1 = mq[exp_cand].r1 ? mq[exp_cand].d1 : CDB_output.data;
      d2 = mq[exp_cand].r2 ? mq[exp_cand].d2 : CDB_output.data;
      check_eq("issue_op", 64'(issue_op), 64'(mq[exp_cand].op));
      check_eq("issue_rd_tag", 64'(issue_rd_tag), 64'(mq[exp_cand].rd));
      check_eq("issue_rs1_data", 64'(issue_rs1_data), 64'(d1));
      check_eq("issue_rs2_data", 64'(issue_rs2_data), 64'(d2));
    end else begin
      check_eq("idle_outputs", {issue_op, issue_rd_tag, issue_rs1_data, issue_rs2_data}, 64'd0);
    end
  endtask

  task automatic model_update();
    bit       acc;
    m_entry_t e;
    if (flush) begin
      mq.delete();
    end else begin
      acc = dispatch_valid && (mq.size() < DEPTH);
      if (exp_issue) mq.delete(exp_cand);
      foreach (mq[i]) begin
        if (!mq[i].r1 && cdb_hit(mq[i].t1)) begin mq[i].r1 = 1'b1; mq[i].d1 = CDB_output.data; end
        if (!mq[i].r2 && cdb_hit(mq[i].t2)) begin mq[i].r2 = 1'b1; mq[i].d2 = CDB_output.data; end
      end
      if (acc) begin
        e.op = dispatch_op;          e.rd = dispatch_rd_tag;
        e.t1 = dispatch_rs1_tag;     e.t2 = dispatch_rs2_tag;
        e.r1 = dispatch_rs1_rdy || cdb_hit(dispatch_rs1_tag);
        e.r2 = dispatch_rs2_rdy || cdb_hit(dispatch_rs2_tag);
        e.d1 = dispatch_rs1_rdy ? dispatch_rs1_data : CDB_output.data;
        e.d2 = dispatch_rs2_rdy ? dispatch_rs2_data : CDB_output.data;
        mq.push_back(e);
      end
    end
  endtask

  // One cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    flush = 1'b0;            dispatch_valid = 1'b0;
    dispatch_op = '0;        dispatch_rd_tag = '0;
    dispatch_rs1_rdy = 1'b0; dispatch_rs2_rdy = 1'b0;
    dispatch_rs1_tag = '0;   dispatch_rs2_tag = '0;
    dispatch_rs1_data = '0;  dispatch_rs2_data = '0;
    CDB_output = '0;         int_fu_ready = 1'b1;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [TAG_W-1:0] rd,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] d1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] d2);
    dispatch_valid = 1'b1;  dispatch_op = op;        dispatch_rd_tag = rd;
    dispatch_rs1_rdy = r1;  dispatch_rs1_tag = t1;   dispatch_rs1_data = d1;
    dispatch_rs2_rdy = r2;  dispatch_rs2_tag = t2;   dispatch_rs2_data = d2;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    CDB_output.valid = 1'b1;
    CDB_output.tag   = tag;
    CDB_output.data  = data;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 64'(iq_count), 64'd0);
    check_eq("rst_ready", 64'(dispatch_ready), 64'd1);
    check_eq("rst_issue", 64'(issue_int), 64'd0);
    check_eq("rst_outputs", {issue_op, issue_rd_tag, issue_rs1_data, issue_rs2_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ready instruction issues the cycle after dispatch.
    set_disp(4'd3, 6'd5, 1'b1, 6'd0, 32'd10, 1'b1, 6'd0, 32'd20);
    step();
    set_idle();
    repeat (2) step();

    // Younger ready entry overtakes an older waiting one.
    set_disp(4'd1, 6'd1, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd2);
    step();
    set_disp(4'd2, 6'd2, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
    step();
    set_idle();
    step();
    set_cdb(6'd7, 32'h55);
    step();
    set_idle();
    repeat (2) step();

    // Full queue rejects dispatch; a single broadcast drains it in age order.
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_disp(4'(i), 6'(32 + i), 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'(i));
      step();
    end
    set_idle();
    set_cdb(6'd9, 32'h99);
    step();
    set_idle();
    repeat (DEPTH + 1) step();

    // FU back-pressure holds ready entries in place.
    int_fu_ready = 1'b0;
    set_disp(4'd6, 6'd16, 1'b1, 6'd0, 32'd61, 1'b1, 6'd0, 32'd62);
    step();
    set_disp(4'd7, 6'd17, 1'b1, 6'd0, 32'd71, 1'b1, 6'd0, 32'd72);
    step();
    dispatch_valid = 1'b0;
    repeat (3) step();
    int_fu_ready = 1'b1;
    repeat (3) step();

    // Dispatch operand captured from the CDB in the same cycle.
    set_disp(4'd8, 6'd18, 1'b1, 6'd0, 32'd1, 1'b0, 6'd12, 32'd0);
    set_cdb(6'd12, 32'hAB);
    step();
    set_idle();
    repeat (2) step();

    // Flush drops the queue and a same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd9, 6'(40 + i), 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0);
      step();
    end
    set_disp(4'd10, 6'd50, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    flush = 1'b1;
    step();
    set_idle();
    step();

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      set_disp(4'd11, 6'(44 + i), 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd0);
      step();
    end
    set_idle();
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_count", 64'(iq_count), 64'd0);
    check_eq("async_rst_issue", 64'(issue_int), 64'd0);
    check_eq("async_rst_ready", 64'(dispatch_ready), 64'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    set_disp(4'd12, 6'd60, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8);
    @(posedge clk);
    model_update();
    #1;
    set_idle();
    repeat (2) step();

    // Random traffic with a narrow tag space so wakeups collide often.
    for (int n = 0; n < 600; n++) begin
      dispatch_valid    = 1'($urandom_range(0, 1));
      dispatch_op       = 4'($urandom_range(0, 15));
      dispatch_rd_tag   = 6'($urandom_range(0, 63));
      dispatch_rs1_rdy  = 1'($urandom_range(0, 1));
      dispatch_rs2_rdy  = 1'($urandom_range(0, 1));
      dispatch_rs1_tag  = 6'($urandom_range(0, 7));
      dispatch_rs2_tag  = 6'($urandom_range(0, 7));
      dispatch_rs1_data = $urandom;
      dispatch_rs2_data = $urandom;
      CDB_output.valid  = 1'($urandom_range(0, 1));
      CDB_output.tag    = 6'($urandom_range(0, 7));
      CDB_output.data   = $urandom;
      int_fu_ready      = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
